// File: rtl/wordred_ctrl_pkg.sv
// Shared types and latency helpers for the wordred iterative reduction controller
// and the wordred datapath it sequences.
package wordred_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Pipeline register enables of one wordred instance (non-zero = register present).
    typedef struct packed {
        int ff_in;
        int ff_sub;
        int ff_mul;
        int ff_sum;
        int ff_out;
    } wordred_params_t;

    function automatic int wordred_lat(wordred_params_t p);
        return ((p.ff_in  != 0) ? 1 : 0) + ((p.ff_sub != 0) ? 1 : 0) +
               ((p.ff_mul != 0) ? 1 : 0) + ((p.ff_sum != 0) ? 1 : 0) +
               ((p.ff_out != 0) ? 1 : 0);
    endfunction

    // T = CH + carry + qH*negCL: the wider of the two addends plus one carry bit.
    function automatic int wordred_logt(int logc, int logqh, int w);
        return (((logc - w) > (logqh + w)) ? (logc - w) : (logqh + w)) + 1;
    endfunction

    // Cycles from the input handshake to the first cycle out_valid is high.
    function automatic int txn_latency(int iter, int lat);
        return iter * (lat + 1) + 1;
    endfunction

endpackage

// File: rtl/wordred.sv
// One Montgomery word-serial reduction step: T = CH + (CL != 0) + qH * (-CL mod 2^W),
// with an optional register after each of the five stages.
module wordred
    import wordred_ctrl_pkg::*;
#(
    parameter int LOGC   = 120,
    parameter int LOGQH  = 26,
    parameter int W      = 34,
    parameter int FF_IN  = 1,
    parameter int FF_SUB = 0,
    parameter int FF_MUL = 1,
    parameter int FF_SUM = 0,
    parameter int FF_OUT = 1
) (
    input  logic                                      clk,
    input  logic [LOGC-1:0]                           c,
    input  logic [LOGQH-1:0]                          qh,
    output logic [wordred_logt(LOGC, LOGQH, W)-1:0]   t
);

    localparam int LOGT = wordred_logt(LOGC, LOGQH, W);
    localparam int CHW  = LOGC - W;
    localparam int PW   = LOGQH + W;

    logic [LOGC-1:0]  c_a;
    logic [LOGQH-1:0] qh_a;
    if (FF_IN != 0) begin : g_ff_in
        always_ff @(posedge clk) begin
            c_a  <= c;
            qh_a <= qh;
        end
    end else begin : g_cb_in
        always_comb begin
            c_a  = c;
            qh_a = qh;
        end
    end

    // Low word negated modulo 2^W; carry is set whenever that negation borrowed.
    logic [CHW-1:0]   ch_s, ch_b;
    logic             carry_s, carry_b;
    logic [W-1:0]     neg_s, neg_b;
    logic [LOGQH-1:0] qh_b;
    always_comb begin
        ch_s    = c_a[LOGC-1:W];
        carry_s = |c_a[W-1:0];
        neg_s   = '0 - c_a[W-1:0];
    end
    if (FF_SUB != 0) begin : g_ff_sub
        always_ff @(posedge clk) begin
            ch_b    <= ch_s;
            carry_b <= carry_s;
            neg_b   <= neg_s;
            qh_b    <= qh_a;
        end
    end else begin : g_cb_sub
        always_comb begin
            ch_b    = ch_s;
            carry_b = carry_s;
            neg_b   = neg_s;
            qh_b    = qh_a;
        end
    end

    logic [PW-1:0]  prod_s, prod_c;
    logic [CHW-1:0] ch_c;
    logic           carry_c;
    always_comb prod_s = PW'(qh_b) * PW'(neg_b);
    if (FF_MUL != 0) begin : g_ff_mul
        always_ff @(posedge clk) begin
            prod_c  <= prod_s;
            ch_c    <= ch_b;
            carry_c <= carry_b;
        end
    end else begin : g_cb_mul
        always_comb begin
            prod_c  = prod_s;
            ch_c    = ch_b;
            carry_c = carry_b;
        end
    end

    logic [LOGT-1:0] sum_s, sum_d;
    always_comb sum_s = LOGT'(ch_c) + LOGT'(carry_c) + LOGT'(prod_c);
    if (FF_SUM != 0) begin : g_ff_sum
        always_ff @(posedge clk) sum_d <= sum_s;
    end else begin : g_cb_sum
        always_comb sum_d = sum_s;
    end

    if (FF_OUT != 0) begin : g_ff_out
        always_ff @(posedge clk) t <= sum_d;
    end else begin : g_cb_out
        always_comb t = sum_d;
    end

endmodule

// File: rtl/wordred_iter_ctrl.sv
// Runs one wordred instance ITER times over a held accumulator to fully reduce
// a double-width product; one transaction in flight at a time.
module wordred_iter_ctrl
    import wordred_ctrl_pkg::*;
#(
    parameter int LOGC   = 120,
    parameter int LOGQH  = 26,
    parameter int W      = 34,
    parameter int ITER   = 2,
    parameter int FF_IN  = 1,
    parameter int FF_SUB = 0,
    parameter int FF_MUL = 1,
    parameter int FF_SUM = 0,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGC-1:0]  in_C,
    input  logic [LOGQH-1:0] in_qH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGC-1:0]  out_T
);

    localparam wordred_params_t WR_P = '{ff_in: FF_IN, ff_sub: FF_SUB, ff_mul: FF_MUL,
                                         ff_sum: FF_SUM, ff_out: FF_OUT};
    localparam int LAT  = wordred_lat(WR_P);
    localparam int LOGT = wordred_logt(LOGC, LOGQH, W);
    localparam int LW   = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int IW   = $clog2(ITER + 1);

    if (LOGT > LOGC) begin : g_bad_logt
        $error("wordred result width LOGT exceeds accumulator width LOGC");
    end
    if (ITER < 1) begin : g_bad_iter
        $error("ITER must be at least 1");
    end

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; valid and its data hold until that edge, ready never waits on valid.
    ctrl_state_t      state, state_nxt;
    logic [LW-1:0]    lat_cnt;
    logic [IW-1:0]    iter_cnt;
    logic [LOGC-1:0]  acc;
    logic [LOGQH-1:0] qH_r;
    logic [LOGT-1:0]  t;
    logic             fire_in, cap, last_cap;

    wordred #(
        .LOGC  (LOGC),
        .LOGQH (LOGQH),
        .W     (W),
        .FF_IN (FF_IN),
        .FF_SUB(FF_SUB),
        .FF_MUL(FF_MUL),
        .FF_SUM(FF_SUM),
        .FF_OUT(FF_OUT)
    ) u_wordred (
        .clk(clk),
        .c  (acc),
        .qh (qH_r),
        .t  (t)
    );

    assign fire_in  = (state == IDLE) && in_valid;
    assign cap      = (state == RUN) && (lat_cnt == LW'(LAT));
    assign last_cap = cap && (iter_cnt == IW'(ITER - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_cap) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_T     = (state == DONE) ? acc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            lat_cnt  <= '0;
            acc      <= '0;
            qH_r     <= '0;
        end else begin
            state <= state_nxt;
            if (fire_in) begin
                acc      <= in_C;
                qH_r     <= in_qH;
                iter_cnt <= '0;
                lat_cnt  <= '0;
            end else if (state == RUN) begin
                // acc and qH_r stay put for LAT+1 cycles so the pipeline output is settled here
                if (cap) begin
                    acc      <= LOGC'(t);
                    lat_cnt  <= '0;
                    iter_cnt <= iter_cnt + 1'b1;
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
            end
        end
    end

    a_lat_no_wrap: assert property (@(posedge clk) disable iff (rst) lat_cnt <= LW'(LAT));
    a_iter_no_wrap: assert property (@(posedge clk) disable iff (rst) iter_cnt <= IW'(ITER));

endmodule
